// File: rtl/dummy_fu_pkg.sv
// Shared types for the dummy functional unit: op codes, iterative-path states
// and default sizing.
package dummy_fu_pkg;

  typedef enum logic [1:0] {
    DFU_ADD    = 2'd0,
    DFU_XOR    = 2'd1,
    DFU_SLL    = 2'd2,
    DFU_POPCNT = 2'd3
  } dfu_op_e;

  typedef enum logic [1:0] {
    DFU_IDLE,
    DFU_BUSY,
    DFU_DONE
  } dfu_state_e;

  localparam int unsigned DFU_CHUNK = 8;

endpackage

// File: rtl/dummy_fu_popcnt_iter.sv
// Iterative population count: counts CHUNK bits per cycle of a latched operand,
// then holds the result in DONE until the writeback port acknowledges it.
import dummy_fu_pkg::*;

module dummy_fu_popcnt_iter #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned CHUNK         = DFU_CHUNK
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     start,
  input  logic [XLEN-1:0]          operand,
  input  logic [TRANS_ID_BITS-1:0] tag,
  output logic                     busy,
  output logic                     done_valid,
  input  logic                     done_ack,
  output logic [XLEN-1:0]          result,
  output logic [TRANS_ID_BITS-1:0] result_tag
);

  localparam int unsigned NCHUNK = XLEN / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CNT_W  = $clog2(XLEN + 1);

  dfu_state_e               state_q, state_d;
  logic [IDX_W-1:0]         idx_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [XLEN-1:0]          opnd_q;
  logic [TRANS_ID_BITS-1:0] tag_q;
  logic [CHUNK-1:0]         chunk;
  logic [CNT_W-1:0]         chunk_ones;
  logic                     last_chunk;

  assign chunk      = opnd_q[idx_q * CHUNK +: CHUNK];
  assign chunk_ones = CNT_W'($countones(chunk));
  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      DFU_IDLE: if (start)      state_d = DFU_BUSY;
      DFU_BUSY: if (last_chunk) state_d = DFU_DONE;
      DFU_DONE: if (done_ack)   state_d = DFU_IDLE;
      default:                  state_d = DFU_IDLE;
    endcase
    if (flush) state_d = DFU_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DFU_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      opnd_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DFU_IDLE && start) begin
        opnd_q <= operand;
        tag_q  <= tag;
        cnt_q  <= '0;
        idx_q  <= '0;
      end else if (state_q == DFU_BUSY) begin
        cnt_q <= cnt_q + chunk_ones;
        idx_q <= last_chunk ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign busy       = (state_q != DFU_IDLE);
  assign done_valid = (state_q == DFU_DONE);
  assign result     = {{(XLEN - CNT_W){1'b0}}, cnt_q};
  assign result_tag = tag_q;

endmodule

// File: rtl/dummy_fu.sv
// Dummy functional unit: fixed-latency ADD/XOR/SLL pipeline plus iterative
// POPCNT sharing one writeback port. Define DUMMY_FU_PERF_EN for perf counters.
import dummy_fu_pkg::*;

module dummy_fu #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned LATENCY       = 2,
  parameter int unsigned CHUNK         = DFU_CHUNK
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [1:0]               op_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     valid_o,
  output logic [31:0]              perf_ops_o,
  output logic [31:0]              perf_stall_o
);

  localparam int unsigned SH_W = $clog2(XLEN);

  typedef struct packed {
    logic                     valid;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
  } pipe_entry_t;

  dfu_op_e                  op;
  logic                     kill, accept;
  logic [XLEN-1:0]          entry_result;
  pipe_entry_t              pipe_q [LATENCY];
  pipe_entry_t              pipe_out;
  logic                     pc_busy, pc_done, done_ack;
  logic [XLEN-1:0]          pc_result;
  logic [TRANS_ID_BITS-1:0] pc_tag;
  logic                     wb_valid;
  logic [XLEN-1:0]          wb_result, res_q;
  logic [TRANS_ID_BITS-1:0] wb_tag, tid_q;

  assign op      = dfu_op_e'(op_i);
  assign kill    = flush_i | rst_i;
  assign ready_o = ~pc_busy;
  assign accept  = valid_i & ready_o & ~kill;

  always_comb begin
    entry_result = '0;
    case (op)
      DFU_ADD: entry_result = operand_a_i + operand_b_i;
      DFU_XOR: entry_result = operand_a_i ^ operand_b_i;
      DFU_SLL: entry_result = operand_a_i << operand_b_i[SH_W-1:0];
      default: entry_result = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: accept & (op != DFU_POPCNT), trans_id: trans_id_i,
                     result: entry_result};
      for (int unsigned i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      if (flush_i)
        for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i].valid <= 1'b0;
    end
  end

  assign pipe_out = pipe_q[LATENCY-1];

  dummy_fu_popcnt_iter #(
    .XLEN          (XLEN),
    .TRANS_ID_BITS (TRANS_ID_BITS),
    .CHUNK         (CHUNK)
  ) u_popcnt (
    .clk        (clk_i),
    .rst        (rst_i),
    .flush      (flush_i),
    .start      (accept & (op == DFU_POPCNT)),
    .operand    (operand_a_i),
    .tag        (trans_id_i),
    .busy       (pc_busy),
    .done_valid (pc_done),
    .done_ack   (done_ack),
    .result     (pc_result),
    .result_tag (pc_tag)
  );

  // The pipeline always owns the port when its last stage is valid; POPCNT waits in DONE.
  assign done_ack  = pc_done & ~pipe_out.valid & ~kill;
  assign wb_valid  = (pipe_out.valid & ~kill) | done_ack;
  assign wb_result = pipe_out.valid ? pipe_out.result : pc_result;
  assign wb_tag    = pipe_out.valid ? pipe_out.trans_id : pc_tag;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q <= '0;
      tid_q <= '0;
    end else if (wb_valid) begin
      res_q <= wb_result;
      tid_q <= wb_tag;
    end
  end

  assign valid_o    = wb_valid;
  assign result_o   = wb_valid ? wb_result : res_q;
  assign trans_id_o = wb_valid ? wb_tag : tid_q;

`ifdef DUMMY_FU_PERF_EN
  logic [31:0] ops_q, stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      if (accept)   ops_q   <= ops_q + 32'd1;
      if (!ready_o) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_ops_o   = ops_q;
  assign perf_stall_o = stall_q;
`else
  assign perf_ops_o   = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_dummy_fu.sv
// Self-checking bench for dummy_fu: table vectors, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_dummy_fu;

  localparam int LAT  = 2;
  localparam int NCH  = 8;

  logic        clk = 1'b0;
  logic        rst, flush, valid;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic [2:0]  tag;
  logic        ready, vout;
  logic [63:0] res;
  logic [2:0]  tid;
  logic [31:0] perf_ops, perf_stall;

  logic        rst2, valid2;
  logic [1:0]  op2;
  logic [63:0] a2, b2;
  logic [2:0]  tag2;
  logic        ready2, vout2;
  logic [63:0] res2;
  logic [2:0]  tid2;
  logic [31:0] perf_ops2, perf_stall2;

  always #5 clk = ~clk;

  dummy_fu #(.XLEN(64), .TRANS_ID_BITS(3), .LATENCY(LAT), .CHUNK(NCH)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(ready),
    .op_i(op), .operand_a_i(a), .operand_b_i(b), .trans_id_i(tag),
    .result_o(res), .trans_id_o(tid), .valid_o(vout),
    .perf_ops_o(perf_ops), .perf_stall_o(perf_stall)
  );

  dummy_fu #(.XLEN(64), .TRANS_ID_BITS(3), .LATENCY(8), .CHUNK(64)) dut2 (
    .clk_i(clk), .rst_i(rst2), .flush_i(1'b0), .valid_i(valid2), .ready_o(ready2),
    .op_i(op2), .operand_a_i(a2), .operand_b_i(b2), .trans_id_i(tag2),
    .result_o(res2), .trans_id_o(tid2), .valid_o(vout2),
    .perf_ops_o(perf_ops2), .perf_stall_o(perf_stall2)
  );

  typedef struct {
    int          due;
    logic [63:0] res;
    logic [2:0]  tag;
  } ev_t;

  typedef struct {
    int          cyc;
    logic [63:0] res;
    logic [2:0]  tag;
  } obs_t;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  tag;
    logic [63:0] exp;
    int          lat;
    int          low;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_low = 0;

  ev_t         pq[$];
  obs_t        seen[$];
  logic        pc_active = 1'b0;
  int          pc_due = 0;
  logic [63:0] pc_res = '0;
  logic [2:0]  pc_tag = '0;
  logic [63:0] last_res = '0;
  logic [2:0]  last_tag = '0;
  logic [31:0] m_ops = '0;
  logic [31:0] m_stall = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [63:0] x,
                                         input logic [63:0] y);
    logic [5:0] sh;
    sh = y[5:0];
    case (o)
      2'd0:    return x + y;
      2'd1:    return x ^ y;
      2'd2:    return x << sh;
      default: return 64'($countones(x));
    endcase
  endfunction

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic step(input logic sv, input logic [1:0] sop, input logic [63:0] sa,
                      input logic [63:0] sb, input logic [2:0] stag,
                      input logic sfl, input logic srs);
    logic exp_ready, exp_valid, pipe_due;
    ev_t  e;
    obs_t o;
    @(negedge clk);
    valid = sv; op = sop; a = sa; b = sb; tag = stag; flush = sfl; rst = srs;
    #1;
    exp_ready = !pc_active;
    pipe_due  = (pq.size() > 0) && (pq[0].due == cyc);
    exp_valid = 1'b0;
    if (!sfl && !srs) begin
      if (pipe_due) begin
        exp_valid = 1'b1; last_res = pq[0].res; last_tag = pq[0].tag;
      end else if (pc_active && cyc >= pc_due) begin
        exp_valid = 1'b1; last_res = pc_res; last_tag = pc_tag;
      end
    end
    chk("ready_o", 64'(ready), 64'(exp_ready));
    chk("valid_o", 64'(vout), 64'(exp_valid));
    chk("result_o", res, last_res);
    chk("trans_id_o", 64'(tid), 64'(last_tag));
`ifdef DUMMY_FU_PERF_EN
    chk("perf_ops_o", 64'(perf_ops), 64'(m_ops));
    chk("perf_stall_o", 64'(perf_stall), 64'(m_stall));
`else
    chk("perf_ops_o", 64'(perf_ops), 64'd0);
    chk("perf_stall_o", 64'(perf_stall), 64'd0);
`endif
    if (ready === 1'b0) ready_low++;
    if (vout === 1'b1) begin
      o.cyc = cyc; o.res = res; o.tag = tid;
      seen.push_back(o);
    end
    if (srs) begin
      pq.delete(); pc_active = 1'b0; last_res = '0; last_tag = '0;
      m_ops = '0; m_stall = '0;
    end else begin
      if (!exp_ready) m_stall++;
      if (sfl) begin
        pq.delete(); pc_active = 1'b0;
      end else begin
        if (pipe_due) void'(pq.pop_front());
        else if (exp_valid) pc_active = 1'b0;
        if (sv && exp_ready) begin
          m_ops++;
          if (sop == 2'd3) begin
            pc_active = 1'b1; pc_due = cyc + 64 / NCH + 1;
            pc_res = ref_op(sop, sa, sb); pc_tag = stag;
          end else begin
            e.due = cyc + LAT; e.res = ref_op(sop, sa, sb); e.tag = stag;
            pq.push_back(e);
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   k;
    obs_t o2[$];
    obs_t ob;

    vecs[0] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd5, 64'd0, 2, 0};
    vecs[1] = '{2'd1, 64'd3, 64'd2, 3'd1, 64'd1, 2, 0};
    vecs[2] = '{2'd2, 64'd1, 64'd63, 3'd2, 64'h8000_0000_0000_0000, 2, 0};
    vecs[3] = '{2'd2, 64'hF0, 64'h104, 3'd3, 64'hF00, 2, 0};
    vecs[4] = '{2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'd7, 64'h8000_0000_0000_0000, 2, 0};
    vecs[5] = '{2'd3, 64'h0F0F_0000_0000_00FF, 64'hDEAD_BEEF, 3'd4, 64'd16, 9, 9};
    vecs[6] = '{2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3'd6, 64'd64, 9, 9};
    vecs[7] = '{2'd3, 64'd0, 64'd5, 3'd0, 64'd0, 9, 9};

    rst = 1'b1; flush = 1'b0; valid = 1'b0; op = '0; a = '0; b = '0; tag = '0;
    rst2 = 1'b1; valid2 = 1'b0; op2 = '0; a2 = '0; b2 = '0; tag2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    idle();
    idle();

    // Table vectors: result, tag, latency and ready_o low-cycle count
    foreach (vecs[i]) begin
      seen.delete(); ready_low = 0;
      step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b0, 1'b0);
      k = 0;
      do begin idle(); k++; end while (seen.size() == 0 && k < 20);
      if (seen.size() == 0) begin
        checks++; errors++;
        $display("FAIL vec%0d_timeout: no valid_o within %0d cycles", i, k);
      end else begin
        chk($sformatf("vec%0d_result", i), seen[0].res, vecs[i].exp);
        chk($sformatf("vec%0d_tag", i), 64'(seen[0].tag), 64'(vecs[i].tag));
        chk($sformatf("vec%0d_latency", i), 64'(k), 64'(vecs[i].lat));
        chk($sformatf("vec%0d_ready_low", i), 64'(ready_low), 64'(vecs[i].low));
      end
    end

    // Back-to-back pipelined ops give consecutive strobes
    seen.delete();
    step(1'b1, 2'd1, 64'd3, 64'd2, 3'd1, 1'b0, 1'b0);
    step(1'b1, 2'd2, 64'd1, 64'd63, 3'd2, 1'b0, 1'b0);
    step(1'b1, 2'd0, 64'h10, 64'h20, 3'd3, 1'b0, 1'b0);
    repeat (4) idle();
    chk("b2b_count", 64'(seen.size()), 64'd3);
    if (seen.size() == 3) begin
      chk("b2b_res0", seen[0].res, 64'd1);
      chk("b2b_res1", seen[1].res, 64'h8000_0000_0000_0000);
      chk("b2b_res2", seen[2].res, 64'h30);
      chk("b2b_tag2", 64'(seen[2].tag), 64'd3);
      chk("b2b_gap1", 64'(seen[1].cyc - seen[0].cyc), 64'd1);
      chk("b2b_gap2", 64'(seen[2].cyc - seen[1].cyc), 64'd1);
    end

    // Flush mid-POPCNT; the ADD offered with the flush must not be accepted
    step(1'b1, 2'd3, 64'hFF, 64'd0, 3'd6, 1'b0, 1'b0);
    repeat (3) idle();
    step(1'b1, 2'd0, 64'd1, 64'd1, 3'd1, 1'b1, 1'b0);
    seen.delete();
    idle();
    chk("flush_pc_ready_next", 64'(ready), 64'd1);
    repeat (12) idle();
    chk("flush_pc_no_strobe", 64'(seen.size()), 64'd0);

    // Flush with two pipelined ops in flight, one of them due that cycle
    step(1'b1, 2'd0, 64'd7, 64'd8, 3'd2, 1'b0, 1'b0);
    step(1'b1, 2'd1, 64'd7, 64'd8, 3'd3, 1'b0, 1'b0);
    seen.delete();
    step(1'b0, 2'd0, '0, '0, '0, 1'b1, 1'b0);
    idle();
    chk("flush_pipe_ready_next", 64'(ready), 64'd1);
    repeat (6) idle();
    chk("flush_pipe_no_strobe", 64'(seen.size()), 64'd0);

    // Reset while BUSY
    step(1'b1, 2'd3, 64'hF, 64'd0, 3'd5, 1'b0, 1'b0);
    repeat (3) idle();
    step(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b1);
    idle();
    chk("rst_busy_ready", 64'(ready), 64'd1);
    chk("rst_busy_result", res, 64'd0);
    chk("rst_busy_tid", 64'(tid), 64'd0);
    seen.delete();
    repeat (10) idle();
    chk("rst_busy_no_strobe", 64'(seen.size()), 64'd0);

    // Perf counters: 10 accepts, 8 stall cycles, then reset
    step(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 2'(i % 3), 64'(i), 64'(i + 1), 3'(i), 1'b0, 1'b0);
    step(1'b1, 2'd3, 64'h3, 64'd0, 3'd1, 1'b0, 1'b0);
    repeat (9) idle();
`ifdef DUMMY_FU_PERF_EN
    chk("perf_ops_10", 64'(perf_ops), 64'd10);
    chk("perf_stall_8", 64'(perf_stall), 64'd8);
`else
    chk("perf_ops_tied", 64'(perf_ops), 64'd0);
    chk("perf_stall_tied", 64'(perf_stall), 64'd0);
`endif
    step(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b1);
    idle();
    chk("perf_ops_after_rst", 64'(perf_ops), 64'd0);
    chk("perf_stall_after_rst", 64'(perf_stall), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [63:0] ra, rb;
      case ($urandom_range(0, 3))
        0:       ra = '1;
        1:       ra = '0;
        default: ra = {$urandom, $urandom};
      endcase
      rb = {$urandom, $urandom};
      step($urandom_range(0, 99) < 70, 2'($urandom_range(0, 3)), ra, rb,
           3'($urandom_range(0, 7)), $urandom_range(0, 49) == 0,
           $urandom_range(0, 199) == 0);
    end
    repeat (12) idle();

    // LATENCY=8, CHUNK=64: ADD and POPCNT both due at k=8; ADD wins, POPCNT at k=9
    for (int kk = 0; kk <= 11; kk++) begin
      @(negedge clk);
      rst2   = 1'b0;
      valid2 = (kk == 0) || (kk == 6);
      op2    = (kk == 6) ? 2'd3 : 2'd0;
      a2     = (kk == 6) ? 64'hFF : 64'd5;
      b2     = 64'd6;
      tag2   = (kk == 6) ? 3'd2 : 3'd1;
      #1;
      if (kk == 6)  chk("coll_ready_issue", 64'(ready2), 64'd1);
      if (kk == 9)  chk("coll_ready_held", 64'(ready2), 64'd0);
      if (kk == 10) chk("coll_ready_free", 64'(ready2), 64'd1);
      if (vout2 === 1'b1) begin
        ob.cyc = kk; ob.res = res2; ob.tag = tid2;
        o2.push_back(ob);
      end
    end
    chk("coll_count", 64'(o2.size()), 64'd2);
    if (o2.size() == 2) begin
      chk("coll_add_cycle", 64'(o2[0].cyc), 64'd8);
      chk("coll_add_tag", 64'(o2[0].tag), 64'd1);
      chk("coll_add_res", o2[0].res, 64'd11);
      chk("coll_pc_cycle", 64'(o2[1].cyc), 64'd9);
      chk("coll_pc_tag", 64'(o2[1].tag), 64'd2);
      chk("coll_pc_res", o2[1].res, 64'd8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
